// File: rtl/vram_pkg.sv
// Shared types and constants for the video RAM arbiter and the CPU address decoder.
package vram_pkg;

    localparam int unsigned VRAM_ADDR_W = 16;
    localparam int unsigned VRAM_DATA_W = 32;

    // Byte base of the VRAM window in the CPU memory map.
    localparam logic [31:0] VRAM_BASE = 32'h0010_0000;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_t;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA fetch has priority, the CPU gets a bounded wait.
// One access per cycle; read data returns one cycle later to the owning requester.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W   = VRAM_ADDR_W,
    parameter int unsigned DATA_W   = VRAM_DATA_W,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o,

    input  logic              vga_req_i,
    input  logic [ADDR_W-1:0] vga_addr_i,
    output logic              vga_gnt_o,
    output logic [DATA_W-1:0] vga_rdata_o,
    output logic              vga_valid_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

    owner_t            owner_q, owner_d;
    logic              cpu_rd_q, cpu_rd_d;
    logic              cpu_busy_q, cpu_busy_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;

    logic cpu_eligible;
    logic cpu_force;
    logic vga_grant;
    logic cpu_grant;

    always_comb begin
        cpu_eligible = cpu_req_i & ~cpu_busy_q;
        cpu_force    = cpu_eligible & (starve_cnt_q == MaxWaitC);
        vga_grant    = vga_req_i & ~cpu_force;
        cpu_grant    = ~vga_grant & cpu_eligible;
    end

    always_comb begin
        mem_en_o    = vga_grant | cpu_grant;
        mem_we_o    = cpu_grant & cpu_we_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (vga_grant) begin
            mem_addr_o = vga_addr_i;
        end else if (cpu_grant) begin
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
        end
        vga_gnt_o = vga_grant;
    end

    // Return path: owner of the previous cycle's access claims mem_rdata_i.
    always_comb begin
        cpu_ack_o   = (owner_q == OWN_CPU);
        vga_valid_o = (owner_q == OWN_VGA);

        cpu_rdata_d = cpu_rdata_q;
        if (cpu_ack_o && cpu_rd_q) begin
            cpu_rdata_d = mem_rdata_i;
        end
        vga_rdata_d = vga_rdata_q;
        if (vga_valid_o) begin
            vga_rdata_d = mem_rdata_i;
        end
        cpu_rdata_o = cpu_rdata_d;
        vga_rdata_o = vga_rdata_d;
    end

    always_comb begin
        owner_d      = OWN_NONE;
        cpu_rd_d     = cpu_grant & ~cpu_we_i;
        cpu_busy_d   = cpu_busy_q;
        starve_cnt_d = starve_cnt_q;

        if (vga_grant) begin
            owner_d = OWN_VGA;
        end else if (cpu_grant) begin
            owner_d = OWN_CPU;
        end

        if (cpu_grant) begin
            cpu_busy_d = 1'b1;
        end else if (cpu_ack_o) begin
            cpu_busy_d = 1'b0;
        end

        if (!cpu_req_i || cpu_grant) begin
            starve_cnt_d = '0;
        end else if (cpu_eligible && (starve_cnt_q < MaxWaitC)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q      <= OWN_NONE;
            cpu_rd_q     <= 1'b0;
            cpu_busy_q   <= 1'b0;
            starve_cnt_q <= '0;
            cpu_rdata_q  <= '0;
            vga_rdata_q  <= '0;
        end else begin
            owner_q      <= owner_d;
            cpu_rd_q     <= cpu_rd_d;
            cpu_busy_q   <= cpu_busy_d;
            starve_cnt_q <= starve_cnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vga_rdata_q  <= vga_rdata_d;
        end
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Shares the single-port video RAM between the ARM core's data-memory port (CPU) and the VGA pixel-fetch path. At most one RAM access is issued per clk cycle. VGA has priority, and a bounded-wait counter guarantees CPU progress. RAM read data returns one cycle after issue and is routed to the requester that owned that access.

Parameters:
ADDR_W, 16, word-address width of video RAM
DATA_W, 32, RAM word width
MAX_WAIT, 4, consecutive denied CPU cycles before the CPU overrides VGA priority (1..15)

Ports:
clk  in  1  system clock (single domain)
reset  in  1  asynchronous, active-low reset (asserted when 0)
cpu_req  in  1  CPU access request; held high until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  read data, valid when cpu_ack
cpu_ack  out  1  one-cycle completion pulse
vga_req  in  1  pixel-word fetch request, per cycle, not held
vga_addr  in  ADDR_W  fetch address
vga_gnt  out  1  combinational: vga_req accepted this cycle
vga_rdata  out  DATA_W  fetched word
vga_valid  out  1  vga_rdata valid; one cycle after vga_gnt
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM synchronous read data (1-cycle latency)

Behaviour:
- Reset (reset=0, async): cpu_ack=0, vga_valid=0, cpu_busy=0, starve_cnt=0, rd_owner=NONE. Any in-flight read is dropped: no ack and no valid after reset releases. cpu_rdata and vga_rdata reset to 0.
- cpu_eligible = cpu_req & !cpu_busy.
- Grant decision (combinational, per cycle):
  - If vga_req & !(cpu_eligible & starve_cnt==MAX_WAIT), grant VGA.
  - Else if cpu_eligible, grant CPU.
  - Else, no grant.
- RAM outputs:
  - mem_en = any grant.
  - mem_we = CPU grant & cpu_we.
  - mem_addr and mem_wdata come from the granted requester. When idle, they are 0.
- vga_gnt = VGA grant. On the next edge, rd_owner <= VGA. In the following cycle: vga_valid=1 and vga_rdata=mem_rdata (registered capture is permitted only if latency is kept at exactly 1 cycle after vga_gnt as seen externally).
- CPU grant: cpu_busy <= 1 and rd_owner <= CPU. The next cycle asserts cpu_ack=1 for exactly one cycle. For a read, cpu_rdata=mem_rdata; for a write, cpu_rdata holds its previous value. cpu_busy clears with the ack. A request still high in the ack cycle is a new request and may be granted from the cycle after the ack.
- Latency: an uncontended CPU access acks 1 cycle after grant, and grant happens in the cycle cpu_req rises.
- starve_cnt (4 bits):
  - Increments, saturating at MAX_WAIT, each cycle cpu_eligible is high and the CPU is not granted.
  - Clears on a CPU grant or when cpu_req is low.
- Bound: with vga_req permanently high, the CPU is granted no later than MAX_WAIT cycles after cpu_req rises. The VGA loses exactly that one slot; vga_gnt=0 tells the fetcher to retry.
- Simultaneous events: CPU-write/VGA-read to the same address in one cycle is impossible, since there is one grant per cycle. The RAM ordering is the grant order.
- Reads and writes never overlap: only one grant per cycle exists.

Decomposition:
- Package vram_pkg: owner_t enum {OWN_NONE, OWN_CPU, OWN_VGA}; localparams ADDR_W/DATA_W defaults; the VRAM base-address constant shared with the CPU address decoder.
- No sub-module. The starvation counter and grant mux are small enough to be inline. A separate grant function in vram_pkg is acceptable.

Test Plan:
- Uncontended CPU write then read: write 0x12345678 to addr 0x0010, then read addr 0x0010 → cpu_ack one cycle after each grant; read returns 0x12345678; mem_we=1 only in the write grant cycle.
- VGA streaming, addr 0x0000..0x0007 on consecutive cycles with cpu_req=0 → vga_gnt=1 each cycle; vga_valid follows 1 cycle later with the matching words; no gaps.
- Starvation with MAX_WAIT=4: vga_req held high, CPU read raised at cycle 0 → CPU granted at cycle 4, vga_gnt=0 in that cycle only, cpu_ack at cycle 5, starve_cnt back to 0.
- Back-to-back CPU: cpu_req held through the ack → no grant in the ack cycle; second grant the cycle after; acks spaced 2 cycles apart.
- Reset mid-read: CPU read granted, then reset=0 before the next edge, then released → no cpu_ack and no vga_valid; all outputs 0; the next request behaves normally.
- Interleaved owners: VGA grant at cycle n, CPU grant at cycle n+1 → vga_valid at n+1, cpu_ack at n+2; data is never routed to the wrong requester.
